qbus_master_seq: RTL and testbench
==================================

// Module: qbus_master_seq
// PURPOSE
//  Parametrised successor to the combinational bus strobe logic in the 1801VM1 core.
//  Sequences one complete MPI/Q-bus master transaction: DATI, DATO, DATOB, and optionally DATIO read-modify-write.
//  Enforces a programmable RPLY timeout that raises a bus error.
//  Sits between control11 (dati/dato/mbyte requests) and the external bus pins.
// PARAMETERS
//  AW        16  address width driven on addr_o
//  DW        16  data width of wdata_i/rdata_o
//  TMO_W      6  timeout counter width
//  TMO_CYC   63  ce-cycles without RPLY before bus error (must fit TMO_W bits, >=1)
//  SETUP_CYC  1  ce-cycles SYNC is held before DIN/DOUT asserts (>=1)
// PORTS
//  clk      in   1   system clock
//  reset    in   1   synchronous, active-high reset
//  ce       in   1   clock enable; all state advances only when ce=1
//  req_rd   in   1   start read (DATI); sampled in S_IDLE
//  req_wr   in   1   start write (DATO/DATOB); sampled in S_IDLE
//  req_byte in   1   byte op (drives WTBT during data phase of write)
//  addr_i   in   AW  transaction address, latched at request accept
//  wdata_i  in   DW  write data, latched at accept (RMW: at rmw_go)
//  rdata_o  out  DW  read data, captured on RPLY in read phase
//  busy_o   out  1   transaction in progress (state != S_IDLE)
//  done_o   out  1   one-ce-cycle pulse on normal completion
//  err_o    out  1   one-ce-cycle pulse on timeout
//  addr_o   out  AW  latched address
//  SYNC     out  1   bus SYNC
//  DIN      out  1   bus DIN
//  DOUT     out  1   bus DOUT
//  WTBT     out  1   bus WTBT
//  BSY      out  1   bus busy (=SYNC)
//  RPLY     in   1   slave reply
// BEHAVIOUR
//  Reset
//  - Enter S_IDLE; counters cleared.
//  - All outputs 0, including rdata_o and addr_o.
//  States
//  - S_IDLE
//    - req_rd takes priority over req_wr when both are set.
//    - Accept: latch addr/data/byte, go S_SETUP.
//    - Ignore requests if RPLY=1 (previous slave not released).
//  - S_SETUP
//    - SYNC=1; WTBT=req_byte&write for the address phase.
//    - Stay SETUP_CYC ce-cycles, then S_DATA.
//  - S_DATA
//    - SYNC=1; DIN=1 (read) or DOUT=1 (write); WTBT=byte flag on write.
//    - Timeout counter loads TMO_CYC on entry, decrements per ce.
//    - RPLY=1: capture data_i into rdata_o if read; go S_END.
//    - Counter reaching 0 with RPLY=0: go S_ERR.
//  - S_END
//    - DIN/DOUT=0, SYNC=1.
//    - Wait RPLY=0, then SYNC=0, pulse done_o, go S_IDLE.
//    - No timeout in this state.
//  - S_ERR
//    - Strobes dropped, err_o pulses, go S_IDLE next ce.
//  Latency
//  - Minimum transaction = SETUP_CYC + 3 ce-cycles (RPLY present on first DATA cycle).
//  Timeout and error
//  - RPLY arriving on the same cycle the counter reaches 0 counts as success (RPLY wins).
//  - err_o and done_o are never high together.
//  Reset mid-transaction
//  - All strobes drop on the same cycle.
//  - No done_o or err_o pulse is produced.
//  Other rules
//  - ce=0 freezes state, counters and outputs.
//  - req_* while busy_o=1 are ignored, not queued.
// CONFIGURATION
//  Macro QBUS_RMW_EN, when defined:
//  - Adds ports req_rmw (in, 1), rmw_wait_o (out, 1) and rmw_go (in, 1).
//  - DATIO cycle: after a read RPLY, enter S_RMW_HOLD.
//    - SYNC stays 1, DIN=0, rmw_wait_o=1.
//    - Wait RPLY=0 and rmw_go=1, then latch wdata_i.
//    - Then S_DATA write phase with DOUT, fresh timeout.
//  - done_o pulses only once, at the end of the write phase.
//  - S_RMW_HOLD has no timeout.
//  Macro QBUS_RMW_EN undefined:
//  - Ports and state absent; every read ends in S_END.
// STRUCTURE
//  Package qbus_pkg:
//  - State encoding localparams (S_IDLE..S_RMW_HOLD).
//  - Default TMO constants.
//  - Transaction-kind enum (RD, WR, WRB, RMW).
//  One sub-module, qbus_tmo_cnt: loadable down-counter with ce, zero flag and synchronous clear.
//  FSM and output registers stay in this module; all bus outputs are registered (glitch-free).
// TESTING
//  1. DATI: req_rd, addr 0o177716, RPLY after 2 DATA cycles with data 0o123456
//     -> rdata_o=0o123456, done_o 1 pulse, SYNC low after RPLY drops.
//  2. DATOB: req_wr+req_byte, addr 0o1001, wdata 0o377
//     -> DOUT=1 and WTBT=1 in DATA; done_o once; DIN never asserted.
//  3. Timeout: req_rd, RPLY held 0, TMO_CYC=63
//     -> err_o pulses exactly 63 ce-cycles after DIN rise; no done_o; strobes 0.
//  4. Boundary: RPLY rises on the counter-zero cycle
//     -> done_o, not err_o; with ce toggling 1/0 the cycle counts double in clk.
//  5. Reset asserted in S_DATA
//     -> next clk SYNC=DIN=DOUT=0, busy_o=0, no done/err pulse; new request then completes normally.
//  6. QBUS_RMW_EN: req_rmw, read 0o000777, rmw_go 4 cycles later with 0o001000
//     -> SYNC never drops, DIN then DOUT, single done_o.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared types and defaults for the Q-bus master sequencer.
// State encoding, default timeout constants and the transaction kind.
package qbus_pkg;

   localparam int unsigned QBUS_TMO_W_DEF   = 6;
   localparam int unsigned QBUS_TMO_CYC_DEF = 63;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_DATA     = 3'd2,
      S_END      = 3'd3,
      S_ERR      = 3'd4,
      S_RMW_HOLD = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RD  = 2'd0,
      WR  = 2'd1,
      WRB = 2'd2,
      RMW = 2'd3
   } kind_e;

   function automatic logic kind_is_write(kind_e k);
      return (k == WR) || (k == WRB);
   endfunction

endpackage

// File: rtl/qbus_tmo_cnt.sv
// Loadable down-counter with clock enable, synchronous clear and zero flag.
// Used for both the address-setup hold and the RPLY timeout.
module qbus_tmo_cnt #(
   parameter int unsigned W = 6
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         ce_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ce_i) begin
         if (load_i) begin
            cnt_d = load_val_i;
         end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/qbus_master_seq.sv
// MPI/Q-bus master transaction sequencer: DATI, DATO, DATOB with RPLY timeout.
// Define QBUS_RMW_EN to add the DATIO read-modify-write cycle (req_rmw/rmw_go/rmw_wait_o).
module qbus_master_seq
   import qbus_pkg::*;
#(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 16,
   parameter int unsigned TMO_W     = QBUS_TMO_W_DEF,
   parameter int unsigned TMO_CYC   = QBUS_TMO_CYC_DEF,
   parameter int unsigned SETUP_CYC = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          req_rd,
   input  logic          req_wr,
   input  logic          req_byte,
`ifdef QBUS_RMW_EN
   input  logic          req_rmw,
   input  logic          rmw_go,
   output logic          rmw_wait_o,
`endif
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] rdata_o,
   output logic [DW-1:0] wdata_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [AW-1:0] addr_o,
   output logic          SYNC,
   output logic          DIN,
   output logic          DOUT,
   output logic          WTBT,
   output logic          BSY,
   input  logic          RPLY
);

   localparam int unsigned SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

   state_e        state_q, state_d;
   kind_e         kind_q, kind_d, req_kind;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdat_q, wdat_d, rdata_q, rdata_d;
   logic          sync_q, din_q, dout_q, wtbt_q, done_q, err_q;
   logic          sync_d, din_d, dout_d, wtbt_d, done_d, err_d;
   logic          req_any;
   logic          set_load, set_dec, set_zero, tmo_load, tmo_dec, tmo_zero;
`ifdef QBUS_RMW_EN
   logic          rmw_wait_q, rmw_wait_d;
`endif

   always_comb begin
      req_kind = WR;
      req_any  = req_rd | req_wr;
`ifdef QBUS_RMW_EN
      req_any  = req_any | req_rmw;
`endif
      if (req_rd) req_kind = RD;
`ifdef QBUS_RMW_EN
      else if (req_rmw) req_kind = RMW;
`endif
      else if (req_byte) req_kind = WRB;
   end

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      set_load = 1'b0;
      set_dec  = 1'b0;
      tmo_load = 1'b0;
      tmo_dec  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A slave still holding RPLY has not released the bus yet.
            if (req_any && !RPLY) begin
               kind_d   = req_kind;
               addr_d   = addr_i;
               wdat_d   = wdata_i;
               set_load = 1'b1;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (set_zero) begin
               tmo_load = 1'b1;
               state_d  = S_DATA;
            end else begin
               set_dec = 1'b1;
            end
         end
         S_DATA: begin
            // RPLY is tested first so a reply on the final count still succeeds.
            if (RPLY) begin
               if (!kind_is_write(kind_q)) rdata_d = data_i;
`ifdef QBUS_RMW_EN
               state_d = (kind_q == RMW) ? S_RMW_HOLD : S_END;
`else
               state_d = S_END;
`endif
            end else if (tmo_zero) begin
               state_d = S_ERR;
            end else begin
               tmo_dec = 1'b1;
            end
         end
         S_END: begin
            if (!RPLY) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERR: state_d = S_IDLE;
`ifdef QBUS_RMW_EN
         S_RMW_HOLD: begin
            if (!RPLY && rmw_go) begin
               wdat_d   = wdata_i;
               kind_d   = WR;
               tmo_load = 1'b1;
               state_d  = S_DATA;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Bus strobes are decoded from the next state and registered.
   always_comb begin
      sync_d = (state_d == S_SETUP) || (state_d == S_DATA) || (state_d == S_END) ||
               (state_d == S_RMW_HOLD);
      din_d  = (state_d == S_DATA) && !kind_is_write(kind_d);
      dout_d = (state_d == S_DATA) && kind_is_write(kind_d);
      wtbt_d = ((state_d == S_SETUP) || (state_d == S_DATA)) && (kind_d == WRB);
      err_d  = (state_d == S_ERR);
`ifdef QBUS_RMW_EN
      rmw_wait_d = (state_d == S_RMW_HOLD);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         kind_q  <= RD;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdata_q <= '0;
         sync_q  <= 1'b0;
         din_q   <= 1'b0;
         dout_q  <= 1'b0;
         wtbt_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef QBUS_RMW_EN
         rmw_wait_q <= 1'b0;
`endif
      end else if (ce) begin
         state_q <= state_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdata_q <= rdata_d;
         sync_q  <= sync_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         wtbt_q  <= wtbt_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef QBUS_RMW_EN
         rmw_wait_q <= rmw_wait_d;
`endif
      end
   end

   qbus_tmo_cnt #(
      .W (SW)
   ) u_setup_cnt (
      .clk_i      (clk),
      .clr_i      (reset),
      .ce_i       (ce),
      .load_i     (set_load),
      .load_val_i (SW'(SETUP_CYC - 1)),
      .dec_i      (set_dec),
      .zero_o     (set_zero)
   );

   // Loaded with TMO_CYC-1 so the zero flag marks the last permitted DATA cycle.
   qbus_tmo_cnt #(
      .W (TMO_W)
   ) u_tmo_cnt (
      .clk_i      (clk),
      .clr_i      (reset),
      .ce_i       (ce),
      .load_i     (tmo_load),
      .load_val_i (TMO_W'(TMO_CYC - 1)),
      .dec_i      (tmo_dec),
      .zero_o     (tmo_zero)
   );

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign addr_o  = addr_q;
   assign rdata_o = rdata_q;
   assign wdata_o = wdat_q;
   assign SYNC    = sync_q;
   assign BSY     = sync_q;
   assign DIN     = din_q;
   assign DOUT    = dout_q;
   assign WTBT    = wtbt_q;
`ifdef QBUS_RMW_EN
   assign rmw_wait_o = rmw_wait_q;
`endif

endmodule

// File: tb/tb_qbus_master_seq.sv
// Self-checking bench for qbus_master_seq: directed literal cases plus randomized traffic
// compared every cycle against a phase/elapsed-count model. Covers QBUS_RMW_EN when defined.
module tb_qbus_master_seq;

   localparam int unsigned AW        = 16;
   localparam int unsigned DW        = 16;
   localparam int unsigned TMO_CYC   = 63;
   localparam int unsigned SETUP_CYC = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1, ce = 1'b0, RPLY = 1'b0;
   logic          req_rd = 1'b0, req_wr = 1'b0, req_byte = 1'b0, req_rmw = 1'b0, rmw_go = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] wdata_i = '0, data_i = '0;
   logic [DW-1:0] rdata_o, wdata_o;
   logic [AW-1:0] addr_o;
   logic          busy_o, done_o, err_o, SYNC, DIN, DOUT, WTBT, BSY, rmw_wait_o;

   always #5 clk = ~clk;

   qbus_master_seq #(
      .AW        (AW),
      .DW        (DW),
      .TMO_W     (6),
      .TMO_CYC   (TMO_CYC),
      .SETUP_CYC (SETUP_CYC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .req_rd   (req_rd),
      .req_wr   (req_wr),
      .req_byte (req_byte),
`ifdef QBUS_RMW_EN
      .req_rmw    (req_rmw),
      .rmw_go     (rmw_go),
      .rmw_wait_o (rmw_wait_o),
`endif
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .data_i   (data_i),
      .rdata_o  (rdata_o),
      .wdata_o  (wdata_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .err_o    (err_o),
      .addr_o   (addr_o),
      .SYNC     (SYNC),
      .DIN      (DIN),
      .DOUT     (DOUT),
      .WTBT     (WTBT),
      .BSY      (BSY),
      .RPLY     (RPLY)
   );
`ifndef QBUS_RMW_EN
   assign rmw_wait_o = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model: bus phase plus ce-cycles elapsed in that phase.
   typedef enum {P_IDLE, P_SETUP, P_DATA, P_END, P_ERR, P_HOLD} phase_t;
   phase_t        m_phase = P_IDLE;
   int            m_n = 0;
   bit            m_write = 0, m_byte = 0, m_rmw = 0, m_done = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdat = '0, m_rdata = '0;

   task automatic model_step();
      if (reset) begin
         m_phase = P_IDLE; m_done = 0; m_write = 0; m_byte = 0; m_rmw = 0;
         m_addr = '0; m_wdat = '0; m_rdata = '0;
         return;
      end
      if (!ce) return;
      m_done = 0;
      case (m_phase)
         P_IDLE: if (!RPLY && (req_rd || req_wr || req_rmw)) begin
            m_rmw   = !req_rd && req_rmw;
            m_write = !req_rd && !req_rmw;
            m_byte  = m_write && req_byte;
            m_addr  = addr_i;
            m_wdat  = wdata_i;
            m_phase = P_SETUP;
            m_n     = 0;
         end
         P_SETUP: begin
            m_n++;
            if (m_n == SETUP_CYC) begin m_phase = P_DATA; m_n = 0; end
         end
         P_DATA: begin
            m_n++;
            if (RPLY) begin
               if (!m_write) m_rdata = data_i;
               m_phase = (m_rmw && !m_write) ? P_HOLD : P_END;
            end else if (m_n == TMO_CYC) begin
               m_phase = P_ERR;
            end
         end
         P_END: if (!RPLY) begin m_phase = P_IDLE; m_done = 1; end
         P_ERR: m_phase = P_IDLE;
         P_HOLD: if (!RPLY && rmw_go) begin
            m_wdat = wdata_i; m_write = 1; m_byte = 0; m_phase = P_DATA; m_n = 0;
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic check_model();
      logic [8:0] act, exp;
      logic       sy;
      sy  = (m_phase == P_SETUP) || (m_phase == P_DATA) || (m_phase == P_END) ||
            (m_phase == P_HOLD);
      act = {SYNC, BSY, DIN, DOUT, WTBT, busy_o, done_o, err_o, rmw_wait_o};
      exp = {sy, sy, (m_phase == P_DATA) && !m_write, (m_phase == P_DATA) && m_write,
             ((m_phase == P_SETUP) || (m_phase == P_DATA)) && m_byte,
             m_phase != P_IDLE, m_done, m_phase == P_ERR, m_phase == P_HOLD};
      n_tests++;
      if (act !== exp || rdata_o !== m_rdata || addr_o !== m_addr || wdata_o !== m_wdat) begin
         n_fail++;
         $display("FAIL model t=%0t ctl got %b want %b rdata %h/%h addr %h/%h wdata %h/%h",
                  $time, act, exp, rdata_o, m_rdata, addr_o, m_addr, wdata_o, m_wdat);
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Inputs are applied before the call; model predicts, then outputs are sampled at negedge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic clr_req();
      req_rd = 0; req_wr = 0; req_byte = 0; req_rmw = 0; rmw_go = 0;
   endtask

   int  n;
   bit  seen, saw_done;
   int  dly, hold;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      reset = 1; ce = 1;
      tick(); tick();
      chk("rst_sync", SYNC, 0); chk("rst_busy", busy_o, 0); chk("rst_rdata", rdata_o, 0);
      chk("rst_addr", addr_o, 0); chk("rst_done", done_o, 0); chk("rst_err", err_o, 0);
      reset = 0;

      // DATI with RPLY after two DATA cycles
      req_rd = 1; addr_i = 16'o177716; tick(); clr_req();
      chk("dati_setup_sync", SYNC, 1); chk("dati_setup_din", DIN, 0);
      chk("dati_addr", addr_o, 16'o177716);
      tick(); chk("dati_din", DIN, 1);
      tick();
      RPLY = 1; data_i = 16'o123456; tick();
      chk("dati_rdata", rdata_o, 16'o123456); chk("dati_end_din", DIN, 0);
      chk("dati_end_sync", SYNC, 1);
      RPLY = 0; tick();
      chk("dati_done", done_o, 1); chk("dati_sync_low", SYNC, 0);
      tick(); chk("dati_done_pulse", done_o, 0);

      // DATOB
      req_wr = 1; req_byte = 1; addr_i = 16'o1001; wdata_i = 16'o377; tick(); clr_req();
      chk("datob_setup_wtbt", WTBT, 1);
      tick();
      chk("datob_dout", DOUT, 1); chk("datob_wtbt", WTBT, 1); chk("datob_din", DIN, 0);
      chk("datob_wdata", wdata_o, 16'o377);
      RPLY = 1; tick(); chk("datob_end_din", DIN, 0);
      RPLY = 0; tick(); chk("datob_done", done_o, 1);
      tick();

      // Timeout: err_o 63 ce-cycles after DIN rises
      req_rd = 1; addr_i = 16'o4; tick(); clr_req();
      tick(); chk("tmo_din", DIN, 1);
      n = 0; seen = 0; saw_done = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick(); n++;
         if (err_o === 1'b1) seen = 1;
         if (done_o === 1'b1) saw_done = 1;
      end
      chk("tmo_cycles", n, 63); chk("tmo_sync", SYNC, 0); chk("tmo_din_off", DIN, 0);
      chk("tmo_no_done", saw_done, 0);
      tick(); chk("tmo_err_pulse", err_o, 0);

      // RPLY on the counter-zero cycle, ce toggling
      req_rd = 1; addr_i = 16'o10; tick(); clr_req();
      tick();
      seen = 0;
      for (int k = 1; k <= 63; k++) begin
         ce = 0; tick();
         ce = 1; RPLY = (k == 63); data_i = 16'o55555; tick();
         if (err_o === 1'b1) seen = 1;
      end
      chk("bnd_no_err", seen, 0); chk("bnd_sync", SYNC, 1); chk("bnd_rdata", rdata_o, 16'o55555);
      RPLY = 0; tick(); chk("bnd_done", done_o, 1); chk("bnd_err", err_o, 0);
      tick();

      // Reset in DATA, then a clean transaction
      req_wr = 1; addr_i = 16'o200; wdata_i = 16'o7; tick(); clr_req();
      tick(); chk("rstm_dout", DOUT, 1);
      reset = 1; tick(); reset = 0;
      chk("rstm_sync", SYNC, 0); chk("rstm_dout_off", DOUT, 0); chk("rstm_busy", busy_o, 0);
      chk("rstm_done", done_o, 0); chk("rstm_err", err_o, 0);
      req_rd = 1; addr_i = 16'o300; tick(); clr_req();
      tick(); RPLY = 1; data_i = 16'o1234; tick();
      RPLY = 0; tick(); chk("rstm_after_done", done_o, 1); chk("rstm_rdata", rdata_o, 16'o1234);
      tick();

`ifdef QBUS_RMW_EN
      // DATIO: SYNC held through the hold phase, one done at the end
      req_rmw = 1; addr_i = 16'o500; tick(); clr_req();
      tick(); chk("rmw_din", DIN, 1);
      RPLY = 1; data_i = 16'o000777; tick();
      chk("rmw_wait", rmw_wait_o, 1); chk("rmw_rdata", rdata_o, 16'o000777);
      RPLY = 0;
      for (int i = 0; i < 4; i++) begin tick(); chk("rmw_hold_sync", SYNC, 1); end
      rmw_go = 1; wdata_i = 16'o001000; tick(); rmw_go = 0;
      chk("rmw_dout", DOUT, 1); chk("rmw_wdata", wdata_o, 16'o001000); chk("rmw_sync", SYNC, 1);
      RPLY = 1; tick(); RPLY = 0; tick(); chk("rmw_done", done_o, 1);
      tick();
`endif

      // Randomized traffic with a reactive slave
      dly = 0; hold = 0;
      for (int c = 0; c < 5000; c++) begin
         reset    = ($urandom_range(0, 499) == 0);
         ce       = ($urandom_range(0, 3) != 0);
         req_rd   = ($urandom_range(0, 4) == 0);
         req_wr   = ($urandom_range(0, 3) == 0);
         req_byte = $urandom_range(0, 1);
`ifdef QBUS_RMW_EN
         req_rmw  = ($urandom_range(0, 5) == 0);
         rmw_go   = ($urandom_range(0, 2) == 0);
`endif
         addr_i   = AW'($urandom);
         wdata_i  = DW'($urandom);
         if (RPLY) begin
            if (!(DIN || DOUT)) begin
               if (hold == 0) RPLY = 0;
               else hold--;
            end
         end else if (DIN || DOUT) begin
            if (dly == 0) begin
               RPLY = 1; data_i = DW'($urandom); hold = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end else begin
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 130) : $urandom_range(0, 4);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
